// File: rtl/return_data_proc.sv
// Return Data Processor: buffers tagged stu_cntl result packets, resolves each tag to a
// manager/lane/stream route through a WU-loaded tag table, and forwards words to noc_cntl.
module return_data_proc #(
    parameter int DATA_W   = 32,
    parameter int TAG_W    = 4,
    parameter int MGR_ID_W = 6,
    parameter int LANE_W   = 5,
    parameter int FIFO_D   = 4
) (
    input  logic                clk,
    input  logic                reset_poweron,
    input  logic                stuc__rdp__valid,
    input  logic [1:0]          stuc__rdp__cntl,
    output logic                rdp__stuc__ready,
    input  logic [TAG_W-1:0]    stuc__rdp__tag,
    input  logic [DATA_W-1:0]   stuc__rdp__data,
    input  logic                wud__rdp__wr,
    input  logic [TAG_W-1:0]    wud__rdp__tag,
    input  logic [MGR_ID_W-1:0] wud__rdp__dest,
    input  logic [LANE_W-1:0]   wud__rdp__laneId,
    input  logic [1:0]          wud__rdp__strmId,
    input  logic                noc__rdp__dp_ready,
    output logic                rdp__noc__dp_valid,
    output logic [1:0]          rdp__noc__dp_cntl,
    output logic [1:0]          rdp__noc__dp_type,
    output logic [MGR_ID_W-1:0] rdp__noc__dp_peId,
    output logic [LANE_W-1:0]   rdp__noc__dp_laneId,
    output logic [1:0]          rdp__noc__dp_strmId,
    output logic [DATA_W-1:0]   rdp__noc__dp_data,
    output logic [7:0]          rdp__sys__drop_count
);
    localparam int PTR_W = $clog2(FIFO_D);
    localparam int NTAG  = 1 << TAG_W;
    localparam logic [1:0] C_SOM = 2'b00, C_SOD = 2'b01, C_MOD = 2'b10, C_EOD = 2'b11;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_D);

    typedef struct packed {
        logic [1:0]        cntl;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } word_t;

    typedef struct packed {
        logic                vld;
        logic [MGR_ID_W-1:0] dest;
        logic [LANE_W-1:0]   lane;
        logic [1:0]          strm;
    } route_t;

    typedef enum logic [1:0] {IDLE, LOOKUP, SEND, DROP} state_t;

    word_t            fifo_q [FIFO_D];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [PTR_W:0]   cnt_q;
    route_t           tbl_q [NTAG];
    route_t           route_q, route_d;
    logic [TAG_W-1:0] rtag_q, rtag_d;
    state_t           state_q, state_d;
    logic [7:0]       drop_q;

    logic  empty, push, pop, load, clr, drop_inc, head_end;
    word_t head;

    assign head             = fifo_q[rptr_q];
    assign empty            = (cnt_q == '0);
    assign rdp__stuc__ready = (cnt_q != FULL_CNT);
    assign push             = stuc__rdp__valid && rdp__stuc__ready;
    assign head_end         = (head.cntl == C_EOD) || (head.cntl == C_SOM);
    assign rdp__sys__drop_count = drop_q;

    always_comb begin
        state_d  = state_q;
        route_d  = route_q;
        rtag_d   = rtag_q;
        pop      = 1'b0;
        load     = 1'b0;
        clr      = 1'b0;
        drop_inc = 1'b0;
        case (state_q)
            IDLE: if (!empty) begin
                if (head.cntl == C_SOM || head.cntl == C_SOD) begin
                    route_d = tbl_q[head.tag];
                    rtag_d  = head.tag;
                    state_d = LOOKUP;
                end else begin
                    // orphan MOD/EOD: discarded word by word, each counted
                    pop      = 1'b1;
                    drop_inc = 1'b1;
                end
            end
            LOOKUP: state_d = route_q.vld ? SEND : DROP;
            SEND: if (!empty && (!rdp__noc__dp_valid || noc__rdp__dp_ready)) begin
                pop  = 1'b1;
                load = 1'b1;
                if (head_end) begin
                    clr     = 1'b1;
                    state_d = IDLE;
                end
            end
            DROP: if (!empty) begin
                pop = 1'b1;
                if (head_end) begin
                    drop_inc = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wptr_q] <= word_t'{stuc__rdp__cntl, stuc__rdp__tag, stuc__rdp__data};
    end

    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
            route_q <= '0;
            rtag_q  <= '0;
            drop_q  <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            state_q <= state_d;
            route_q <= route_d;
            rtag_q  <= rtag_d;
            if (drop_inc && drop_q != 8'hFF) drop_q <= drop_q + 1'b1;
        end
    end

    // Write is ordered after the end-of-packet clear so a same-cycle reload survives.
    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            for (int i = 0; i < NTAG; i++) tbl_q[i] <= '0;
        end else begin
            if (clr) tbl_q[rtag_q].vld <= 1'b0;
            if (wud__rdp__wr)
                tbl_q[wud__rdp__tag] <= route_t'{1'b1, wud__rdp__dest, wud__rdp__laneId, wud__rdp__strmId};
        end
    end

    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            rdp__noc__dp_valid  <= 1'b0;
            rdp__noc__dp_cntl   <= '0;
            rdp__noc__dp_type   <= '0;
            rdp__noc__dp_peId   <= '0;
            rdp__noc__dp_laneId <= '0;
            rdp__noc__dp_strmId <= '0;
            rdp__noc__dp_data   <= '0;
        end else if (load) begin
            rdp__noc__dp_valid  <= 1'b1;
            rdp__noc__dp_cntl   <= head.cntl;
            rdp__noc__dp_type   <= 2'b01;
            rdp__noc__dp_peId   <= route_q.dest;
            rdp__noc__dp_laneId <= route_q.lane;
            rdp__noc__dp_strmId <= route_q.strm;
            rdp__noc__dp_data   <= head.data;
        end else if (noc__rdp__dp_ready) begin
            rdp__noc__dp_valid  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_return_data_proc.sv
// Bench for return_data_proc: packet-level reference model with a per-cycle output compare,
// plus directed scenarios carrying hand-computed expectations.
module tb_return_data_proc;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, wr, dp_ready;
    logic [1:0]  in_cntl, wr_strm;
    logic [3:0]  in_tag, wr_tag;
    logic [31:0] in_data;
    logic [5:0]  wr_dest;
    logic [4:0]  wr_lane;
    logic        dp_valid;
    logic [1:0]  dp_cntl, dp_type, dp_strm;
    logic [5:0]  dp_pe;
    logic [4:0]  dp_lane;
    logic [31:0] dp_data;
    logic [7:0]  drop;

    always #5 clk = ~clk;

    return_data_proc dut (
        .clk(clk), .reset_poweron(rst),
        .stuc__rdp__valid(in_valid), .stuc__rdp__cntl(in_cntl), .rdp__stuc__ready(in_ready),
        .stuc__rdp__tag(in_tag), .stuc__rdp__data(in_data),
        .wud__rdp__wr(wr), .wud__rdp__tag(wr_tag), .wud__rdp__dest(wr_dest),
        .wud__rdp__laneId(wr_lane), .wud__rdp__strmId(wr_strm),
        .noc__rdp__dp_ready(dp_ready), .rdp__noc__dp_valid(dp_valid), .rdp__noc__dp_cntl(dp_cntl),
        .rdp__noc__dp_type(dp_type), .rdp__noc__dp_peId(dp_pe), .rdp__noc__dp_laneId(dp_lane),
        .rdp__noc__dp_strmId(dp_strm), .rdp__noc__dp_data(dp_data), .rdp__sys__drop_count(drop)
    );

    typedef struct packed {
        logic [1:0]  cntl;
        logic [5:0]  pe;
        logic [4:0]  lane;
        logic [1:0]  strm;
        logic [31:0] data;
    } ow_t;

    int n_chk = 0, n_fail = 0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    ow_t        expq[$];
    ow_t        log_w[$];
    bit         mt_v [16];
    logic [5:0] mt_d [16];
    logic [4:0] mt_l [16];
    logic [1:0] mt_s [16];
    int         m_drop = 0, acc_cnt = 0, cyc = 0, sod_cyc = 0, rise_cyc = 0;
    bit         in_pkt = 0, fwd = 0, prev_hold = 0, pv = 0;
    logic [3:0] m_tag;
    ow_t        held, got;

    function automatic void m_dropinc();
        if (m_drop < 255) m_drop++;
    endfunction

    always @(posedge clk)
        if (!rst && wr) begin
            mt_v[wr_tag] = 1'b1;
            mt_d[wr_tag] = wr_dest;
            mt_l[wr_tag] = wr_lane;
            mt_s[wr_tag] = wr_strm;
        end

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            expq.delete();
            for (int i = 0; i < 16; i++) mt_v[i] = 1'b0;
            m_drop = 0; in_pkt = 0; fwd = 0; prev_hold = 0; pv = 0;
        end else begin
            got = '{dp_cntl, dp_pe, dp_lane, dp_strm, dp_data};
            if (prev_hold) chk("hold_stable", {dp_valid, got}, {1'b1, held});
            if (dp_valid && !pv) rise_cyc = cyc;
            pv = dp_valid;
            if (dp_valid && dp_ready) begin
                chk("dp_type", dp_type, 2'b01);
                if (expq.size() == 0) chk("unexpected_out", got, 0);
                else chk("out_word", got, expq.pop_front());
                log_w.push_back(got);
            end
            prev_hold = dp_valid && !dp_ready;
            held = got;
            if (in_valid && in_ready) begin
                acc_cnt++;
                if (in_cntl == 2'b00 || in_cntl == 2'b01) begin
                    if (in_cntl == 2'b01) sod_cyc = cyc;
                    m_tag = in_tag;
                    fwd   = mt_v[in_tag];
                    if (fwd) expq.push_back('{in_cntl, mt_d[m_tag], mt_l[m_tag], mt_s[m_tag], in_data});
                    if (in_cntl == 2'b00) begin
                        if (fwd) mt_v[m_tag] = 1'b0; else m_dropinc();
                    end else in_pkt = 1;
                end else if (in_pkt) begin
                    if (fwd) expq.push_back('{in_cntl, mt_d[m_tag], mt_l[m_tag], mt_s[m_tag], in_data});
                    if (in_cntl == 2'b11) begin
                        in_pkt = 0;
                        if (fwd) mt_v[m_tag] = 1'b0; else m_dropinc();
                    end
                end else m_dropinc();
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr_tbl(input logic [3:0] t, input logic [5:0] d, input logic [4:0] l, input logic [1:0] s);
        wr = 1; wr_tag = t; wr_dest = d; wr_lane = l; wr_strm = s;
        tick(1);
        wr = 0;
    endtask

    task automatic send_word(input logic [1:0] c, input logic [3:0] t, input logic [31:0] d);
        int w;
        in_valid = 1; in_cntl = c; in_tag = t; in_data = d;
        w = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            if (++w > 200) begin chk("send_timeout", 1, 0); break; end
        end
        tick(1);
        in_valid = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, found;
        rst = 1; in_valid = 0; in_cntl = 0; in_tag = 0; in_data = 0;
        wr = 0; wr_tag = 0; wr_dest = 0; wr_lane = 0; wr_strm = 0; dp_ready = 1;
        #1;
        chk("reset_outs", {dp_valid, dp_cntl, dp_type, dp_pe, dp_lane, dp_strm, dp_data, drop}, 0);
        tick(2);
        rst = 0;
        chk("reset_ready", in_ready, 1);

        // 1: forwarded packet
        wr_tbl(3, 5, 2, 1);
        send_word(2'b01, 3, 1); send_word(2'b10, 3, 2);
        send_word(2'b10, 3, 3); send_word(2'b11, 3, 4);
        tick(10);
        chk("t1_count", log_w.size(), 4);
        chk("t1_w0", log_w[0], {2'b01, 6'd5, 5'd2, 2'd1, 32'd1});
        chk("t1_w1", log_w[1], {2'b10, 6'd5, 5'd2, 2'd1, 32'd2});
        chk("t1_w3", log_w[3], {2'b11, 6'd5, 5'd2, 2'd1, 32'd4});
        chk("t1_latency_ge3", (rise_cyc - sod_cyc) >= 3, 1);
        chk("t1_drop", drop, 0);

        // 2: unknown tag and freed tag both drop
        log_w.delete();
        send_word(2'b00, 7, 32'hAA); tick(8);
        chk("t2_drop1", drop, 1);
        send_word(2'b00, 3, 32'h55); tick(8);
        chk("t2_drop2", drop, 2);
        chk("t2_no_out", log_w.size(), 0);

        // 3: backpressure on an 8-word packet
        wr_tbl(3, 9, 7, 2);
        dp_ready = 0;
        base = acc_cnt;
        fork
            for (int i = 0; i < 8; i++)
                send_word(i == 0 ? 2'b01 : (i == 7 ? 2'b11 : 2'b10), 3, 100 + i);
            begin
                tick(15);
                chk("t3_ready_low", in_ready, 0);
                chk("t3_buffered", acc_cnt - base, 5);
                tick(5);
                dp_ready = 1;
            end
        join
        tick(20);
        chk("t3_count", log_w.size(), 8);
        chk("t3_first", log_w[0], {2'b01, 6'd9, 5'd7, 2'd2, 32'd100});
        chk("t3_last", log_w[7], {2'b11, 6'd9, 5'd7, 2'd2, 32'd107});

        // 4: orphans after fresh reset
        rst = 1; tick(2); rst = 0;
        log_w.delete();
        send_word(2'b10, 0, 1); send_word(2'b11, 0, 2); tick(6);
        chk("t4_drop", drop, 2);
        wr_tbl(4, 33, 17, 3);
        send_word(2'b01, 4, 7); send_word(2'b11, 4, 8); tick(10);
        chk("t4_count", log_w.size(), 2);
        chk("t4_w1", log_w[1], {2'b11, 6'd33, 5'd17, 2'd3, 32'd8});

        // 5: table write coinciding with the EOD pop of the same tag
        wr_tbl(3, 5, 2, 1);
        fork
            begin send_word(2'b01, 3, 32'h10); send_word(2'b11, 3, 32'h11); end
            begin
                found = 0;
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    if (dp_valid && dp_cntl == 2'b01 && dp_data == 32'h10) begin found = 1; break; end
                end
                chk("t5_sod_seen", found, 1);
                #1;
                wr = 1; wr_tag = 3; wr_dest = 40; wr_lane = 20; wr_strm = 3;
                tick(1);
                wr = 0;
            end
        join
        tick(6);
        send_word(2'b01, 3, 32'h20); send_word(2'b10, 3, 32'h21); send_word(2'b11, 3, 32'h22);
        tick(10);
        chk("t5_count", log_w.size(), 7);
        chk("t5_new_route", log_w[6], {2'b11, 6'd40, 5'd20, 2'd3, 32'h22});
        chk("t5_drop", drop, 2);

        // 6: reset mid-packet, then drop-count saturation
        wr_tbl(5, 1, 1, 1);
        send_word(2'b01, 5, 1); send_word(2'b10, 5, 2); tick(2);
        chk("t6_midpkt_valid", dp_valid, 1);
        rst = 1;
        #1;
        chk("t6_reset_outs", {dp_valid, dp_cntl, dp_type, dp_pe, dp_lane, dp_strm, dp_data, drop}, 0);
        chk("t6_reset_ready", in_ready, 1);
        tick(1); rst = 0;
        send_word(2'b01, 5, 3); send_word(2'b11, 5, 4); tick(8);
        chk("t6_table_cleared", drop, 1);
        for (int i = 0; i < 255; i++) send_word(2'b00, 9, i);
        tick(10);
        chk("t6_sat", drop, 255);
        send_word(2'b00, 9, 0); tick(8);
        chk("t6_sat_hold", drop, 255);
        chk("drop_model", drop, m_drop);
        chk("expq_drained", expq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
